mips_bus_ram_responder: RTL and testbench

- Memory-side responder for the CPU's Avalon-style bus interface: address, read, write, byteenable, writedata, readdata, waitrequest.
- Holds a word-addressed RAM mapped at BASE_ADDR.
- Stretches every transfer by WAIT_CYCLES so CPU stall logic is exercised under test.
- Used by bus-CPU testbenches in place of a zero-latency memory.

---
 rtl/mips_bus_pkg.sv | 24 ++
 rtl/mips_bus_addr_decode.sv | 23 ++
 rtl/mips_bus_ram_responder.sv | 127 ++++++++++++
 tb/tb_mips_bus_ram_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types, constants and byte-lane merge for the bus RAM responder
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mips_bus_addr_decode.sv
// rtl/mips_bus_addr_decode.sv - byte address to RAM word index, range and alignment flags
module mips_bus_addr_decode
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          IDX_W       = 10
) (
  input  logic [31:0]      address,
  output logic [IDX_W-1:0] index,
  output logic             in_range,
  output logic             misaligned
);

  logic [31:0] w_offset;

  // Addresses below the base wrap to huge offsets and so fall out of range.
  assign w_offset   = address - BASE_ADDR;
  assign index      = w_offset[IDX_W+1:2];
  assign in_range   = ({2'b00, w_offset[31:2]} < 32'(DEPTH_WORDS));
  assign misaligned = |w_offset[1:0];

endmodule

// File: rtl/mips_bus_ram_responder.sv
// rtl/mips_bus_ram_responder.sv - wait-stretched word RAM slave for the CPU bus
module mips_bus_ram_responder
  import mips_bus_pkg::*;
#(
  parameter string       INIT_FILE   = "",
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        access_err
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_rd;
  logic        r_wr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_readdata;
  logic        r_access_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0] w_index;
  logic             w_in_range;
  logic             w_misaligned;
  logic             w_req;
  logic             w_err;
  logic             w_do_write;

  // Decode runs on the latched address so mid-transfer address changes are ignored.
  mips_bus_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_decode (
    .address   (r_addr),
    .index     (w_index),
    .in_range  (w_in_range),
    .misaligned(w_misaligned)
  );

  assign w_req      = read | write;
  assign w_err      = !w_in_range | w_misaligned | (r_rd & r_wr);
  assign w_do_write = (r_state == ACK) & r_wr & !r_rd & w_in_range;
  assign readdata   = r_readdata;
  assign access_err = r_access_err;

  always_comb begin
    w_next      = r_state;
    waitrequest = 1'b0;
    case (r_state)
      IDLE: begin
        waitrequest = w_req;
        if (w_req) w_next = WAIT;
      end
      WAIT: begin
        waitrequest = 1'b1;
        if (!w_req)                 w_next = IDLE;
        else if (r_cnt == WAIT_LAST) w_next = ACK;
      end
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_addr       <= 32'd0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_be         <= 4'd0;
      r_wdata      <= 32'd0;
      r_readdata   <= 32'd0;
      r_access_err <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_access_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= address;
            r_rd    <= read;
            r_wr    <= write;
            r_be    <= byteenable;
            r_wdata <= writedata;
            r_cnt   <= 4'd1;
          end
        end
        WAIT: begin
          if (w_next == ACK) begin
            r_access_err <= w_err;
            if (r_rd) begin
              r_readdata <= (!w_in_range || r_wr) ? 32'd0 : r_mem[w_index];
            end
          end else if (w_next == WAIT) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_cnt <= 4'd0;
          end
        end
        default: r_cnt <= 4'd0;
      endcase
    end
  end

  // RAM contents survive reset; a reset before ACK means this edge never sees ACK.
  always_ff @(posedge clk) begin
    if (w_do_write) r_mem[w_index] <= be_merge(r_mem[w_index], r_wdata, r_be);
  end

endmodule

// File: tb/tb_mips_bus_ram_responder.sv
// tb/tb_mips_bus_ram_responder.sv - directed self-checking bench for the bus RAM responder
module tb_mips_bus_ram_responder;

  logic        clk;
  logic        reset;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        read0, write0, read1, write1;
  logic [31:0] readdata0, readdata1;
  logic        waitrequest0, waitrequest1;
  logic        access_err0, access_err1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd;
  logic        er;
  int          nw;

  mips_bus_ram_responder #(
    .INIT_FILE  (""),
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'hBFC00000),
    .WAIT_CYCLES(2)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .read       (read0),
    .write      (write0),
    .byteenable (byteenable),
    .writedata  (writedata),
    .readdata   (readdata0),
    .waitrequest(waitrequest0),
    .access_err (access_err0)
  );

  mips_bus_ram_responder #(
    .INIT_FILE  (""),
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'hBFC00000),
    .WAIT_CYCLES(1)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .read       (read1),
    .write      (write1),
    .byteenable (byteenable),
    .writedata  (writedata),
    .readdata   (readdata1),
    .waitrequest(waitrequest1),
    .access_err (access_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered just after a rising edge; returns just after the edge that leaves ACK.
  task automatic xfer(input int sel, input logic r, input logic w, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic err, output int nwait);
    logic done;
    address    = addr;
    byteenable = be;
    writedata  = wd;
    if (sel == 1) begin read1 = r; write1 = w; end
    else          begin read0 = r; write0 = w; end
    nwait = 0;
    rdata = 32'd0;
    err   = 1'b0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if ((sel == 1) ? waitrequest1 : waitrequest0) nwait++;
      else begin
        rdata = (sel == 1) ? readdata1 : readdata0;
        err   = (sel == 1) ? access_err1 : access_err0;
        done  = 1'b1;
      end
    end
    if (!done) check("xfer_timeout", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    read0 = 1'b0; write0 = 1'b0; read1 = 1'b0; write1 = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    address = 32'd0; byteenable = 4'd0; writedata = 32'd0;
    read0 = 1'b0; write0 = 1'b0; read1 = 1'b0; write1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_waitrequest", 32'(waitrequest0), 32'd0);
    check("rst_readdata", readdata0, 32'd0);
    check("rst_access_err", 32'(access_err0), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    xfer(0, 1'b0, 1'b1, 32'hBFC00000, 4'hF, 32'h24020005, rd, er, nw);
    check("wr0_wait", 32'(nw), 32'd3);
    check("wr0_err", 32'(er), 32'd0);
    xfer(0, 1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'd0, rd, er, nw);
    check("rd0_wait", 32'(nw), 32'd3);
    check("rd0_data", rd, 32'h24020005);
    check("rd0_err", 32'(er), 32'd0);

    xfer(0, 1'b0, 1'b1, 32'hBFC00004, 4'hF, 32'h11223344, rd, er, nw);
    xfer(0, 1'b0, 1'b1, 32'hBFC00004, 4'b0101, 32'hAABBCCDD, rd, er, nw);
    xfer(0, 1'b1, 1'b0, 32'hBFC00004, 4'h0, 32'd0, rd, er, nw);
    check("partial_wr", rd, 32'h11BB33DD);

    xfer(0, 1'b0, 1'b1, 32'hBFC00004, 4'h0, 32'hFFFFFFFF, rd, er, nw);
    check("be0_err", 32'(er), 32'd0);
    xfer(0, 1'b1, 1'b0, 32'hBFC00004, 4'h0, 32'd0, rd, er, nw);
    check("be0_nochange", rd, 32'h11BB33DD);

    xfer(0, 1'b0, 1'b1, 32'hBFC01000, 4'hF, 32'h12345678, rd, er, nw);
    check("oor_wr_err", 32'(er), 32'd1);
    xfer(0, 1'b1, 1'b0, 32'hBFC01000, 4'h0, 32'd0, rd, er, nw);
    check("oor_rd_data", rd, 32'd0);
    check("oor_rd_err", 32'(er), 32'd1);
    xfer(0, 1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'd0, rd, er, nw);
    check("oor_word0", rd, 32'h24020005);
    xfer(0, 1'b1, 1'b0, 32'hBFBFFFFC, 4'h0, 32'd0, rd, er, nw);
    check("below_base_err", 32'(er), 32'd1);
    xfer(0, 1'b0, 1'b1, 32'hBFC00FFC, 4'hF, 32'hCAFEF00D, rd, er, nw);
    check("last_wr_err", 32'(er), 32'd0);
    xfer(0, 1'b1, 1'b0, 32'hBFC00FFC, 4'h0, 32'd0, rd, er, nw);
    check("last_rd_data", rd, 32'hCAFEF00D);

    xfer(0, 1'b1, 1'b0, 32'hBFC00006, 4'h0, 32'd0, rd, er, nw);
    check("misal_data", rd, 32'h11BB33DD);
    check("misal_err", 32'(er), 32'd1);

    xfer(0, 1'b1, 1'b1, 32'hBFC00000, 4'hF, 32'hFFFFFFFF, rd, er, nw);
    check("rdwr_err", 32'(er), 32'd1);
    check("rdwr_data", rd, 32'd0);
    xfer(0, 1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'd0, rd, er, nw);
    check("rdwr_nowrite", rd, 32'h24020005);

    // Abort: request dropped in the first WAIT cycle.
    address = 32'hBFC00004; read0 = 1'b1;
    @(posedge clk); #1;
    read0 = 1'b0;
    @(negedge clk);
    check("abort_wait_hi", 32'(waitrequest0), 32'd1);
    @(negedge clk);
    check("abort_idle_wr", 32'(waitrequest0), 32'd0);
    check("abort_err", 32'(access_err0), 32'd0);
    check("abort_rdata_held", readdata0, 32'h24020005);
    @(negedge clk);
    check("abort_err2", 32'(access_err0), 32'd0);
    @(posedge clk); #1;
    xfer(0, 1'b1, 1'b0, 32'hBFC00004, 4'h0, 32'd0, rd, er, nw);
    check("post_abort_wait", 32'(nw), 32'd3);
    check("post_abort_data", rd, 32'h11BB33DD);

    // Reset while a write sits in WAIT.
    address = 32'hBFC00004; byteenable = 4'hF; writedata = 32'h00000000; write0 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    write0 = 1'b0;
    reset  = 1'b0;
    #1;
    check("rstmid_waitreq", 32'(waitrequest0), 32'd0);
    check("rstmid_readdata", readdata0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    xfer(0, 1'b1, 1'b0, 32'hBFC00004, 4'h0, 32'd0, rd, er, nw);
    check("rstmid_wait", 32'(nw), 32'd3);
    check("rstmid_old", rd, 32'h11BB33DD);

    // WAIT_CYCLES=1 instance: back-to-back reads.
    xfer(1, 1'b0, 1'b1, 32'hBFC00000, 4'hF, 32'hA5A5A5A5, rd, er, nw);
    xfer(1, 1'b0, 1'b1, 32'hBFC00004, 4'hF, 32'h5A5A0001, rd, er, nw);
    xfer(1, 1'b1, 1'b0, 32'hBFC00000, 4'h0, 32'd0, rd, er, nw);
    check("b2b_wait0", 32'(nw), 32'd2);
    check("b2b_data0", rd, 32'hA5A5A5A5);
    xfer(1, 1'b1, 1'b0, 32'hBFC00004, 4'h0, 32'd0, rd, er, nw);
    check("b2b_wait1", 32'(nw), 32'd2);
    check("b2b_data1", rd, 32'h5A5A0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
